// File: rtl/dcache_rd_ctrl.sv
// Load-port read controller for the write-through L1 data cache: hit/miss handling, miss issue and replay.
// Optional build macro DCACHE_CTRL_SIG_EN drives the access signature outputs from the stored paddr.
module dcache_rd_ctrl #(
  parameter int unsigned     IDX_W       = 12,
  parameter int unsigned     OFF_W       = 4,
  parameter int unsigned     TAG_W       = 44,
  parameter int unsigned     WAYS        = 4,
  parameter int unsigned     ID_W        = 2,
  parameter logic [ID_W-1:0] RD_TX_ID    = ID_W'(1),
  parameter logic [63:0]     CACHED_BASE = 64'h8000_0000,
  parameter logic [63:0]     CACHED_LEN  = 64'h4000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cache_en_i,
  input  logic                   req_valid_i,
  input  logic [IDX_W-1:0]       addr_index_i,
  input  logic [TAG_W-1:0]       addr_tag_i,
  input  logic                   tag_valid_i,
  input  logic                   kill_req_i,
  input  logic [1:0]             data_size_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  output logic [63:0]            data_rdata_o,
  output logic                   miss_req_o,
  input  logic                   miss_ack_i,
  output logic                   miss_nc_o,
  output logic                   miss_we_o,
  output logic [63:0]            miss_paddr_o,
  output logic [WAYS-1:0]        miss_vld_bits_o,
  output logic [2:0]             miss_size_o,
  output logic [ID_W-1:0]        miss_id_o,
  output logic [13:0]            miss_signature_o,
  input  logic                   miss_replay_i,
  input  logic                   miss_rtrn_vld_i,
  input  logic                   wr_cl_vld_i,
  output logic                   rd_req_o,
  input  logic                   rd_ack_i,
  output logic                   rd_tag_only_o,
  output logic [IDX_W-OFF_W-1:0] rd_idx_o,
  output logic [OFF_W-1:0]       rd_off_o,
  output logic [TAG_W-1:0]       rd_tag_o,
  output logic [13:0]            signature_o,
  input  logic [63:0]            rd_data_i,
  input  logic [WAYS-1:0]        rd_vld_bits_i,
  input  logic [WAYS-1:0]        rd_hit_oh_i
);

  typedef enum logic [2:0] {
    IDLE, READ, MISS_REQ, MISS_WAIT, KILL_MISS, REPLAY_REQ, REPLAY_READ
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       size_q, size_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WAYS-1:0]  vld_q, vld_d;

  logic [TAG_W-1:0] cmp_tag;
  logic [63:0]      paddr, paddr_q;
  logic             nc, hit;

  // The live tag is only compared in the first read cycle; every later state uses the captured one.
  assign cmp_tag = (state_q == READ) ? addr_tag_i : tag_q;
  assign paddr   = 64'({cmp_tag, idx_q});
  assign paddr_q = 64'({tag_q, idx_q});
  assign nc      = !cache_en_i || (paddr < CACHED_BASE) || (paddr >= CACHED_BASE + CACHED_LEN);
  assign hit     = |rd_hit_oh_i;

  assign rd_tag_o        = cmp_tag;
  assign rd_tag_only_o   = 1'b0;
  assign miss_we_o       = 1'b0;
  assign miss_nc_o       = miss_req_o & nc;
  assign miss_id_o       = miss_req_o ? RD_TX_ID : '0;
  assign miss_paddr_o    = paddr_q & ~((64'd1 << size_q) - 64'd1);
  assign miss_vld_bits_o = vld_q;
  assign miss_size_o     = {1'b0, size_q};

`ifdef DCACHE_CTRL_SIG_EN
  assign signature_o      = paddr_q[19:6];
  assign miss_signature_o = paddr_q[19:6];
`else
  assign signature_o      = '0;
  assign miss_signature_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      size_q  <= '0;
      tag_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      size_q  <= size_d;
      tag_q   <= tag_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    size_d        = size_q;
    tag_d         = tag_q;
    vld_d         = vld_q;
    rd_req_o      = 1'b0;
    rd_idx_o      = idx_q[IDX_W-1:OFF_W];
    rd_off_o      = idx_q[OFF_W-1:0];
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    data_rdata_o  = '0;
    miss_req_o    = 1'b0;

    case (state_q)
      IDLE: begin
        rd_req_o = req_valid_i;
        rd_idx_o = addr_index_i[IDX_W-1:OFF_W];
        rd_off_o = addr_index_i[OFF_W-1:0];
        if (req_valid_i && rd_ack_i) begin
          data_gnt_o = 1'b1;
          idx_d      = addr_index_i;
          size_d     = data_size_i;
          state_d    = READ;
        end
      end
      READ: begin
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = IDLE;
        end else if (!tag_valid_i) begin
          rd_req_o = 1'b1;
        end else begin
          tag_d = addr_tag_i;
          if (wr_cl_vld_i) begin
            state_d = REPLAY_REQ;
          end else if (hit && !nc) begin
            // Hit cycle doubles as the IDLE-style accept slot for the next load.
            data_rvalid_o = 1'b1;
            data_rdata_o  = rd_data_i;
            rd_req_o      = req_valid_i;
            rd_idx_o      = addr_index_i[IDX_W-1:OFF_W];
            rd_off_o      = addr_index_i[OFF_W-1:0];
            if (req_valid_i && rd_ack_i) begin
              data_gnt_o = 1'b1;
              idx_d      = addr_index_i;
              size_d     = data_size_i;
            end else begin
              state_d = IDLE;
            end
          end else begin
            vld_d   = rd_vld_bits_i;
            state_d = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        miss_req_o = 1'b1;
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = miss_ack_i ? KILL_MISS : IDLE;
        end else if (miss_ack_i) begin
          state_d = MISS_WAIT;
        end else if (miss_replay_i) begin
          state_d = REPLAY_REQ;
        end
      end
      MISS_WAIT: begin
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = miss_rtrn_vld_i ? IDLE : KILL_MISS;
        end else if (miss_rtrn_vld_i) begin
          state_d = REPLAY_REQ;
        end
      end
      KILL_MISS: begin
        if (miss_rtrn_vld_i) state_d = IDLE;
      end
      REPLAY_REQ: begin
        rd_req_o = 1'b1;
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = IDLE;
        end else if (rd_ack_i) begin
          state_d = REPLAY_READ;
        end
      end
      REPLAY_READ: begin
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = IDLE;
        end else if (wr_cl_vld_i) begin
          state_d = REPLAY_REQ;
        end else if (hit) begin
          data_rvalid_o = 1'b1;
          data_rdata_o  = rd_data_i;
          state_d       = IDLE;
        end else begin
          vld_d   = rd_vld_bits_i;
          state_d = MISS_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_rd_ctrl.sv
// Self-checking bench for dcache_rd_ctrl: vector table of single loads plus multi-cycle kill/collision/reset sequences.
module tb_dcache_rd_ctrl;

  logic        clk, rst_n;
  logic        cache_en, req_valid, tag_valid, kill_req, miss_ack, miss_replay, miss_rtrn;
  logic        wr_cl, rd_ack;
  logic [11:0] addr_index;
  logic [43:0] addr_tag;
  logic [1:0]  data_size;
  logic [63:0] rd_data;
  logic [3:0]  rd_vld_bits, rd_hit_oh;

  logic        data_gnt_o, data_rvalid_o, miss_req_o, miss_nc_o, miss_we_o;
  logic        rd_req_o, rd_tag_only_o;
  logic [63:0] data_rdata_o, miss_paddr_o;
  logic [3:0]  miss_vld_bits_o;
  logic [2:0]  miss_size_o;
  logic [1:0]  miss_id_o;
  logic [13:0] miss_signature_o, signature_o;
  logic [7:0]  rd_idx_o;
  logic [3:0]  rd_off_o;
  logic [43:0] rd_tag_o;

  dcache_rd_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .cache_en_i(cache_en), .req_valid_i(req_valid),
    .addr_index_i(addr_index), .addr_tag_i(addr_tag), .tag_valid_i(tag_valid),
    .kill_req_i(kill_req), .data_size_i(data_size), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .miss_req_o(miss_req_o),
    .miss_ack_i(miss_ack), .miss_nc_o(miss_nc_o), .miss_we_o(miss_we_o),
    .miss_paddr_o(miss_paddr_o), .miss_vld_bits_o(miss_vld_bits_o), .miss_size_o(miss_size_o),
    .miss_id_o(miss_id_o), .miss_signature_o(miss_signature_o), .miss_replay_i(miss_replay),
    .miss_rtrn_vld_i(miss_rtrn), .wr_cl_vld_i(wr_cl), .rd_req_o(rd_req_o), .rd_ack_i(rd_ack),
    .rd_tag_only_o(rd_tag_only_o), .rd_idx_o(rd_idx_o), .rd_off_o(rd_off_o), .rd_tag_o(rd_tag_o),
    .signature_o(signature_o), .rd_data_i(rd_data), .rd_vld_bits_i(rd_vld_bits),
    .rd_hit_oh_i(rd_hit_oh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] idx;
    logic [43:0] tag;
    logic [1:0]  size;
    logic        en;
    logic [3:0]  hit;
    logic [3:0]  vld;
    logic [63:0] data;
    logic        exp_hit;
    logic        exp_nc;
    logic [63:0] exp_paddr;
  } vec_t;

  typedef struct {
    logic        cd;
    logic [63:0] data;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   gnt_cnt = 0;
  int   rv_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_gnt_o)    gnt_cnt++;
      if (data_rvalid_o) rv_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr();
    cache_en = 1'b1; req_valid = 1'b0; tag_valid = 1'b0; kill_req = 1'b0;
    miss_ack = 1'b0; miss_replay = 1'b0; miss_rtrn = 1'b0; wr_cl = 1'b0; rd_ack = 1'b0;
    addr_index = '0; addr_tag = '0; data_size = '0; rd_data = '0;
    rd_vld_bits = '0; rd_hit_oh = '0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_rv(input string nm);
    sb_t e;
    chk({nm, "_rvalid"}, 64'(data_rvalid_o), 64'd1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: got rvalid expected empty scoreboard to hold an entry", nm);
    end else begin
      e = sb.pop_front();
      if (e.cd) chk({nm, "_rdata"}, data_rdata_o, e.data);
    end
  endtask

  // Issue one load from IDLE with same-cycle grant.
  task automatic issue(input logic [11:0] idx, input logic [1:0] sz, input logic cd,
                       input logic [63:0] d);
    cyc(); clr();
    req_valid = 1'b1; addr_index = idx; data_size = sz; rd_ack = 1'b1;
    smp();
    chk("gnt", 64'(data_gnt_o), 64'd1);
    sb.push_back('{cd, d});
  endtask

  task automatic access(input vec_t v);
    logic [13:0] exp_sig;
`ifdef DCACHE_CTRL_SIG_EN
    logic [63:0] pa;
    pa      = 64'({v.tag, v.idx});
    exp_sig = pa[19:6];
`else
    exp_sig = '0;
`endif
    issue(v.idx, v.size, 1'b1, v.data);
    chk("rd_req_idle", 64'(rd_req_o), 64'd1);
    chk("rd_idx_idle", 64'(rd_idx_o), 64'(v.idx[11:4]));
    chk("rd_off_idle", 64'(rd_off_o), 64'(v.idx[3:0]));
    cyc();
    cache_en = v.en; req_valid = 1'b0; rd_ack = 1'b0; addr_index = '0;
    tag_valid = 1'b1; addr_tag = v.tag; rd_hit_oh = v.hit; rd_vld_bits = v.vld; rd_data = v.data;
    smp();
    chk("rd_tag_read", 64'(rd_tag_o), 64'(v.tag));
    if (v.exp_hit) expect_rv("hit");
    else chk("no_rv_miss", 64'(data_rvalid_o), 64'd0);
    cyc();
    tag_valid = 1'b0; rd_hit_oh = '0; rd_vld_bits = ~v.vld; rd_data = '0; addr_tag = '0;
    if (!v.exp_hit) begin
      smp();
      chk("miss_req", 64'(miss_req_o), 64'd1);
      chk("miss_paddr", miss_paddr_o, v.exp_paddr);
      chk("miss_nc", 64'(miss_nc_o), 64'(v.exp_nc));
      chk("miss_id", 64'(miss_id_o), 64'd1);
      chk("miss_size", 64'(miss_size_o), 64'({1'b0, v.size}));
      chk("miss_vld", 64'(miss_vld_bits_o), 64'(v.vld));
      chk("miss_we", 64'(miss_we_o), 64'd0);
      chk("miss_sig", 64'(miss_signature_o), 64'(exp_sig));
      chk("sig", 64'(signature_o), 64'(exp_sig));
      cyc(); miss_ack = 1'b1;
      smp(); chk("miss_req_hold", 64'(miss_req_o), 64'd1);
      cyc(); miss_ack = 1'b0;
      smp(); chk("miss_wait_noreq", 64'(miss_req_o), 64'd0);
      cyc(); miss_rtrn = 1'b1;
      smp(); chk("rtrn_no_rv", 64'(data_rvalid_o), 64'd0);
      cyc(); miss_rtrn = 1'b0; rd_ack = 1'b1;
      smp();
      chk("replay_req", 64'(rd_req_o), 64'd1);
      chk("replay_idx", 64'(rd_idx_o), 64'(v.idx[11:4]));
      chk("replay_off", 64'(rd_off_o), 64'(v.idx[3:0]));
      cyc(); rd_ack = 1'b0; rd_hit_oh = 4'b0001; rd_data = v.data;
      smp();
      chk("replay_tag", 64'(rd_tag_o), 64'(v.tag));
      expect_rv("replay");
      cyc(); clr();
    end
  endtask

  initial begin
    vecs[0] = '{12'h040, 44'h80000, 2'd3, 1'b1, 4'b0010, 4'b1111, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0, 64'h0};
    vecs[1] = '{12'h040, 44'h80000, 2'd3, 1'b1, 4'b0000, 4'b0111, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 64'h8000_0040};
    vecs[2] = '{12'h000, 44'h00001, 2'd3, 1'b1, 4'b0001, 4'b1010, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b1, 64'h0000_1000};
    vecs[3] = '{12'h123, 44'h80000, 2'd2, 1'b0, 4'b0100, 4'b0001, 64'h0000_0000_0000_CAFE, 1'b0, 1'b1, 64'h8000_0120};
    vecs[4] = '{12'hFF8, 44'hBFFFF, 2'd3, 1'b1, 4'b1000, 4'b1111, 64'h0000_0000_0BAD_F00D, 1'b1, 1'b0, 64'h0};
    vecs[5] = '{12'h000, 44'hC0000, 2'd3, 1'b1, 4'b0001, 4'b0011, 64'h5555_5555_5555_5555, 1'b0, 1'b1, 64'hC000_0000};
    vecs[6] = '{12'hFFF, 44'h7FFFF, 2'd1, 1'b1, 4'b0010, 4'b1100, 64'h6666_6666_6666_6666, 1'b0, 1'b1, 64'h7FFF_FFFE};
    vecs[7] = '{12'h7A5, 44'h80001, 2'd0, 1'b1, 4'b0000, 4'b0101, 64'h7777_7777_7777_7777, 1'b0, 1'b0, 64'h8000_17A5};

    clr(); cache_en = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    smp();
    chk("reset_outs", 64'(|{data_gnt_o, data_rvalid_o, data_rdata_o, miss_req_o, miss_nc_o,
                            miss_we_o, miss_paddr_o, miss_vld_bits_o, miss_size_o, miss_id_o,
                            miss_signature_o, rd_req_o, rd_tag_only_o, rd_idx_o, rd_off_o,
                            rd_tag_o, signature_o}), 64'd0);
    cyc(); rst_n = 1'b1; clr();

    for (int unsigned i = 0; i < 8; i++) access(vecs[i]);

    // Back-to-back: second request granted in the hit cycle of the first.
    issue(12'h100, 2'd3, 1'b1, 64'h0101_0101_0101_0101);
    cyc(); rd_ack = 1'b1; req_valid = 1'b1; addr_index = 12'h200; data_size = 2'd3;
    tag_valid = 1'b1; addr_tag = 44'h80000; rd_hit_oh = 4'b0100; rd_data = 64'h0101_0101_0101_0101;
    smp();
    expect_rv("b2b_first");
    chk("b2b_gnt", 64'(data_gnt_o), 64'd1);
    chk("b2b_idx", 64'(rd_idx_o), 64'h20);
    sb.push_back('{1'b1, 64'h0202_0202_0202_0202});
    cyc(); req_valid = 1'b0; rd_ack = 1'b0; rd_data = 64'h0202_0202_0202_0202;
    smp();
    expect_rv("b2b_second");
    chk("b2b_no_gnt", 64'(data_gnt_o), 64'd0);
    cyc(); clr();

    // Tag arrives late: READ re-requests on the stored index.
    issue(12'h080, 2'd2, 1'b1, 64'h0808_0808_0808_0808);
    cyc(); req_valid = 1'b0; rd_ack = 1'b0; addr_index = '0;
    smp();
    chk("late_rereq", 64'(rd_req_o), 64'd1);
    chk("late_idx", 64'(rd_idx_o), 64'h08);
    chk("late_no_rv", 64'(data_rvalid_o), 64'd0);
    cyc(); tag_valid = 1'b1; addr_tag = 44'h80000; rd_hit_oh = 4'b0001; rd_data = 64'h0808_0808_0808_0808;
    smp(); expect_rv("late");
    cyc(); clr();

    // Write collision during the hit cycle forces a replay.
    issue(12'h0C0, 2'd3, 1'b1, 64'h0C0C_0C0C_0C0C_0C0C);
    cyc(); req_valid = 1'b0; rd_ack = 1'b0; tag_valid = 1'b1; addr_tag = 44'h80002;
    rd_hit_oh = 4'b0010; rd_data = 64'h0C0C_0C0C_0C0C_0C0C; wr_cl = 1'b1;
    smp(); chk("coll_no_rv", 64'(data_rvalid_o), 64'd0);
    cyc(); clr(); rd_ack = 1'b1;
    smp();
    chk("coll_rereq", 64'(rd_req_o), 64'd1);
    chk("coll_idx", 64'(rd_idx_o), 64'h0C);
    cyc(); rd_ack = 1'b0; rd_hit_oh = 4'b0010; rd_data = 64'h0C0C_0C0C_0C0C_0C0C;
    smp();
    chk("coll_tag", 64'(rd_tag_o), 64'h80002);
    expect_rv("coll");
    cyc(); clr();

    // Kill while waiting for refill: one dummy rvalid, then drain the return in KILL_MISS.
    issue(12'h040, 2'd3, 1'b0, 64'h0);
    cyc(); req_valid = 1'b0; rd_ack = 1'b0; tag_valid = 1'b1; addr_tag = 44'h80000;
    cyc(); clr(); miss_ack = 1'b1;
    smp(); chk("kw_miss_req", 64'(miss_req_o), 64'd1);
    cyc(); miss_ack = 1'b0; kill_req = 1'b1;
    smp(); expect_rv("kill_wait");
    cyc(); kill_req = 1'b0; req_valid = 1'b1; rd_ack = 1'b1;
    smp();
    chk("km_no_gnt", 64'(data_gnt_o), 64'd0);
    chk("km_no_rdreq", 64'(rd_req_o), 64'd0);
    chk("km_no_rv", 64'(data_rvalid_o), 64'd0);
    cyc(); clr(); miss_rtrn = 1'b1;
    smp(); chk("km_rtrn_no_rv", 64'(data_rvalid_o), 64'd0);
    cyc(); clr(); req_valid = 1'b1;
    smp(); chk("km_back_idle", 64'(rd_req_o), 64'd1);

    // Kill together with miss ack in MISS_REQ still waits for the return.
    issue(12'h050, 2'd3, 1'b0, 64'h0);
    cyc(); req_valid = 1'b0; rd_ack = 1'b0; tag_valid = 1'b1; addr_tag = 44'h80000;
    cyc(); clr(); miss_ack = 1'b1; kill_req = 1'b1;
    smp(); expect_rv("kill_ack");
    cyc(); clr(); req_valid = 1'b1;
    smp(); chk("ka_in_kill_miss", 64'(rd_req_o), 64'd0);
    cyc(); clr(); miss_rtrn = 1'b1;
    cyc(); clr(); req_valid = 1'b1;
    smp(); chk("ka_back_idle", 64'(rd_req_o), 64'd1);

    // Kill and refill return in the same cycle consume the return.
    issue(12'h060, 2'd3, 1'b0, 64'h0);
    cyc(); req_valid = 1'b0; rd_ack = 1'b0; tag_valid = 1'b1; addr_tag = 44'h80000;
    cyc(); clr(); miss_ack = 1'b1;
    cyc(); clr(); kill_req = 1'b1; miss_rtrn = 1'b1;
    smp(); expect_rv("kill_rtrn");
    cyc(); clr(); req_valid = 1'b1;
    smp(); chk("kr_back_idle", 64'(rd_req_o), 64'd1);

    // Miss replay request bounces straight to a re-read.
    issue(12'h070, 2'd3, 1'b1, 64'h0707_0707_0707_0707);
    cyc(); req_valid = 1'b0; rd_ack = 1'b0; tag_valid = 1'b1; addr_tag = 44'h80000;
    cyc(); clr(); miss_replay = 1'b1;
    smp(); chk("mr_miss_req", 64'(miss_req_o), 64'd1);
    cyc(); clr(); rd_ack = 1'b1;
    smp();
    chk("mr_rereq", 64'(rd_req_o), 64'd1);
    chk("mr_idx", 64'(rd_idx_o), 64'h07);
    cyc(); clr(); rd_hit_oh = 4'b1000; rd_data = 64'h0707_0707_0707_0707;
    smp(); expect_rv("miss_replay");
    cyc(); clr();

    smp();
    chk("one_rv_per_gnt", 64'(rv_cnt), 64'(gnt_cnt));
    chk("sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of MISS_WAIT.
    issue(12'h040, 2'd3, 1'b1, 64'h0);
    cyc(); req_valid = 1'b0; rd_ack = 1'b0; tag_valid = 1'b1; addr_tag = 44'h80000;
    cyc(); clr(); miss_ack = 1'b1;
    cyc(); clr();
    smp(); chk("rw_in_wait", 64'(miss_req_o), 64'd0);
    cyc(); clr(); cache_en = 1'b0; rst_n = 1'b0;
    smp();
    chk("mid_reset_outs", 64'(|{data_gnt_o, data_rvalid_o, data_rdata_o, miss_req_o, miss_nc_o,
                                miss_we_o, miss_paddr_o, miss_vld_bits_o, miss_size_o, miss_id_o,
                                miss_signature_o, rd_req_o, rd_tag_only_o, rd_idx_o, rd_off_o,
                                rd_tag_o, signature_o}), 64'd0);
    sb.delete();
    cyc(); rst_n = 1'b1; clr(); req_valid = 1'b1;
    smp(); chk("post_reset_idle", 64'(rd_req_o), 64'd1);
    cyc(); clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_rd_ctrl.md
Name: dcache_rd_ctrl

Overview:
- Read controller for one high-priority load port (LSU load unit or PTW) of the write-through L1 data cache.
- Converts core load requests into cache-memory read/tag-compare requests.
- On a miss or a non-cacheable access, issues a miss request to the miss unit, waits for the refill, then replays the read and returns data to the core.

Parameters:
- IDX_W, 12: core address index width (set index plus byte offset).
- OFF_W, 4: byte-offset width inside a cacheline.
- TAG_W, 44: physical tag width.
- WAYS, 4: set associativity.
- ID_W, 2: transaction ID width.
- RD_TX_ID, 1: ID used for every miss request.
- CACHED_BASE, 64'h8000_0000: start of the cacheable region.
- CACHED_LEN, 64'h4000_0000: length of the cacheable region.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cache_en_i  in  1  cache enable from the miss unit
- req_valid_i  in  1  core load request
- addr_index_i  in  IDX_W  address index
- addr_tag_i  in  TAG_W  physical tag, valid with tag_valid_i
- tag_valid_i  in  1  tag available
- kill_req_i  in  1  abort the outstanding load
- data_size_i  in  2  log2 of access bytes
- data_gnt_o  out  1  request granted
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  64  load data
- miss_req_o  out  1  miss request
- miss_ack_i  in  1  miss accepted
- miss_nc_o  out  1  non-cacheable
- miss_we_o  out  1  always 0
- miss_paddr_o  out  64  miss physical address
- miss_vld_bits_o  out  WAYS  captured way-valid bits
- miss_size_o  out  3  {0, data_size}
- miss_id_o  out  ID_W  RD_TX_ID
- miss_signature_o  out  14  access signature
- miss_replay_i  in  1  retry the miss later
- miss_rtrn_vld_i  in  1  refill done
- wr_cl_vld_i  in  1  cacheline write active (readout collision)
- rd_req_o  out  1  memory read request
- rd_ack_i  in  1  read granted
- rd_tag_only_o  out  1  always 0
- rd_idx_o  out  IDX_W-OFF_W  set index
- rd_off_o  out  OFF_W  offset
- rd_tag_o  out  TAG_W  compare tag
- signature_o  out  14  signature to memory
- rd_data_i  in  64  read data (cycle after ack)
- rd_vld_bits_i  in  WAYS  way-valid bits
- rd_hit_oh_i  in  WAYS  one-hot hit

Behaviour:
- States: IDLE, READ, MISS_REQ, MISS_WAIT, KILL_MISS, REPLAY_REQ, REPLAY_READ.
- Reset: IDLE, all registers and outputs 0.
- paddr = {tag, index}.
- NC = !cache_en_i OR paddr outside [CACHED_BASE, CACHED_BASE+CACHED_LEN).
- rd_tag_o = addr_tag_i in READ, otherwise the stored tag.
- data_rdata_o = rd_data_i whenever data_rvalid_o is high due to a hit.

IDLE:
- req_valid_i drives rd_req_o combinationally with idx/off from addr_index_i.
- rd_ack_i: data_gnt_o=1 for that cycle, store index and size, go READ.

READ (data/hit valid this cycle):
- kill_req_i: data_rvalid_o=1 (dummy data), go IDLE.
- Else tag_valid_i=0: re-assert rd_req_o on the stored index; stay in READ.
- Else store tag. wr_cl_vld_i=1 goes REPLAY_REQ.
  - Hit (|rd_hit_oh_i) and !NC: data_rvalid_o=1. In the same cycle, accept a new request (back-to-back grant on rd_ack_i, stay READ), else go IDLE.
  - Miss or NC: capture rd_vld_bits_i, go MISS_REQ.

MISS_REQ:
- miss_req_o=1.
- miss_paddr_o = paddr with the low data_size bits cleared.
- Priority when several inputs are high: kill, then ack, then replay.
  - kill_req_i: data_rvalid_o=1; go KILL_MISS if miss_ack_i, else IDLE.
  - miss_ack_i: go MISS_WAIT.
  - miss_replay_i: go REPLAY_REQ.

MISS_WAIT:
- kill_req_i: data_rvalid_o=1, go KILL_MISS.
- miss_rtrn_vld_i: go REPLAY_REQ.
- If both arrive together, kill wins and the return is consumed: go IDLE.

KILL_MISS:
- Wait for miss_rtrn_vld_i, then go IDLE. No further rvalid.

REPLAY_REQ:
- rd_req_o on the stored index. rd_ack_i goes REPLAY_READ.
- kill_req_i: data_rvalid_o=1, go IDLE.

REPLAY_READ:
- Compare against the stored tag.
- kill: rvalid, IDLE.
- Collision: REPLAY_REQ.
- Hit (NC lines also hit after refill): rvalid, IDLE.
- Miss: MISS_REQ.

Invariants:
- Exactly one data_rvalid_o per granted request.
- data_gnt_o is never asserted outside IDLE or a READ hit.

Optional Feature:
- DCACHE_CTRL_SIG_EN defined: signature_o and miss_signature_o = paddr[19:6] (stored tag/index).
- Not defined: both tied to 14'h0.

Test Plan:
- Request idx=0x040, rd_ack same cycle; next cycle tag_valid with rd_hit_oh=4'b0010, rd_data=0xDEADBEEF -> gnt 1 cycle, rvalid with 0xDEADBEEF 1 cycle after gnt.
- Miss at paddr 0x8000_0040, size=3 -> miss_req with paddr 0x8000_0040, nc=0, id=1. Then miss_ack; then rtrn_vld -> replay read, hit -> rvalid.
- Same access at tag giving paddr 0x1000 (outside region) -> miss_nc_o=1, even if rd_hit_oh is nonzero in READ.
- kill_req_i during MISS_WAIT -> immediate rvalid; no second rvalid after miss_rtrn_vld_i; returns to IDLE.
- wr_cl_vld_i=1 in the READ cycle with a hit -> no rvalid; REPLAY_REQ re-read -> rvalid.
- Assert rst_ni low mid-MISS_WAIT -> all outputs 0, IDLE.
